// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the 1-in/3-out router: buffers a whole payload,
// then sends header, payload and parity on the router input while honouring busy.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_addr,
  input  logic [5:0]       req_len,
  input  logic             req_bad_par,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic             busy,
  output logic             pkt_valid,
  output logic [7:0]       pkt_data,
  output logic             tx_done,
  output logic             req_err,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_e;

  state_e             state_q,     state_d;
  logic [1:0]         addr_q,      addr_d;
  logic [5:0]         len_q,       len_d;
  logic               bad_par_q,   bad_par_d;
  logic [7:0]         par_acc_q,   par_acc_d;
  logic [5:0]         wr_ptr_q,    wr_ptr_d;
  logic [5:0]         rd_ptr_q,    rd_ptr_d;
  logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic [7:0]         pkt_data_q,  pkt_data_d;
  logic               tx_done_q,   tx_done_d;
  logic               req_err_q,   req_err_d;
  logic [CNT_W-1:0]   pkt_cnt_q,   pkt_cnt_d;

  logic [7:0] mem [64];
  logic       mem_we;
  logic       req_fire;
  logic       pl_fire;
  logic       gap_done;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign pl_ready  = (state_q == S_LOAD) && !reset;
  assign req_fire  = req_valid && req_ready;
  assign pl_fire   = pl_valid && pl_ready;
  assign gap_done  = (gap_cnt_q >= GAP_W'(GAP_CYCLES - 1));

  // rd_ptr_q always points at the byte to load after the one currently on pkt_data.
  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    bad_par_d   = bad_par_q;
    par_acc_d   = par_acc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    tx_done_d   = 1'b0;
    req_err_d   = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          if (req_len == 6'd0 || req_addr == 2'd3) begin
            req_err_d = 1'b1;
          end else begin
            addr_d    = req_addr;
            len_d     = req_len;
            bad_par_d = req_bad_par;
            par_acc_d = {req_len, req_addr};
            wr_ptr_d  = 6'd0;
            rd_ptr_d  = 6'd0;
            state_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pl_fire) begin
          mem_we    = 1'b1;
          par_acc_d = par_acc_q ^ pl_data;
          wr_ptr_d  = wr_ptr_q + 6'd1;
          if (wr_ptr_q == len_q - 6'd1) begin
            state_d     = S_HEADER;
            pkt_valid_d = 1'b1;
            pkt_data_d  = {len_q, addr_q};
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_d    = S_PAYLOAD;
          pkt_data_d = mem[0];
          rd_ptr_d   = 6'd1;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          if (rd_ptr_q == len_q) begin
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            pkt_data_d  = par_acc_q ^ {7'b0, bad_par_q};
          end else begin
            pkt_data_d = mem[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 6'd1;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          state_d    = S_GAP;
          tx_done_d  = 1'b1;
          pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
          pkt_data_d = 8'h00;
          gap_cnt_d  = '0;
        end
      end
      S_GAP: begin
        if (!gap_done) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else if (!busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      bad_par_q   <= 1'b0;
      par_acc_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      tx_done_q   <= 1'b0;
      req_err_q   <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      bad_par_q   <= bad_par_d;
      par_acc_q   <= par_acc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      tx_done_q   <= tx_done_d;
      req_err_q   <= req_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  // NOTE: the payload buffer has no reset; it is always written before it is read.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr_q] <= pl_data;
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign tx_done   = tx_done_q;
  assign req_err   = req_err_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus pushes the expected bus bytes of each
// packet, a negedge monitor pops and compares them as the DUT transfers.
module tb_router_pkt_tx;

  localparam int GAP   = 2;
  localparam int CW    = 16;
  localparam int BOUND = 400;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_addr = '0;
  logic [5:0]    req_len = '0;
  logic          req_bad_par = 1'b0;
  logic [7:0]    pl_data = '0;
  logic          pl_valid = 1'b0;
  logic          pl_ready;
  logic          busy = 1'b0;
  logic          pkt_valid;
  logic [7:0]    pkt_data;
  logic          tx_done;
  logic          req_err;
  logic [CW-1:0] pkt_cnt;

  always #5 clock = ~clock;

  router_pkt_tx #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_bad_par(req_bad_par),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .busy(busy), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .tx_done(tx_done), .req_err(req_err), .pkt_cnt(pkt_cnt)
  );

  typedef enum int {K_HDR, K_PL, K_LAST, K_PAR} kind_e;
  typedef struct {
    logic [7:0] data;
    kind_e      kind;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pl_buf[$];
  exp_t       mon_e;

  int tests = 0;
  int fails = 0;

  // Monitor-side model state
  int exp_cnt   = 0;
  bit in_pkt    = 1'b0;
  bit wait_par  = 1'b0;
  bit exp_done  = 1'b0;
  int gap_left  = 0;
  int hold_cnt  = 0;

  // Busy generator controls
  bit         busy_rand = 1'b0;
  bit         trig_en   = 1'b0;
  logic [7:0] trig_byte = '0;
  int         busy_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no/unexpected event, expected the opposite at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected bus traffic for one packet, straight from the packet format rules.
  task automatic push_expect(input logic [1:0] a, input logic [5:0] l, input logic bp);
    logic [7:0] h;
    logic [7:0] par;
    h   = {l, a};
    par = h;
    exp_q.push_back('{h, K_HDR});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back('{pl_buf[i], (i == int'(l) - 1) ? K_LAST : K_PL});
      par = par ^ pl_buf[i];
    end
    if (bp) par = par ^ 8'h01;
    exp_q.push_back('{par, K_PAR});
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic bp, input bit gappy);
    bit acc;
    int n;
    int idx;
    req_valid = 1'b1; req_addr = a; req_len = l; req_bad_par = bp;
    acc = 1'b0; n = 0;
    while (!acc && n < BOUND) begin
      @(negedge clock);
      acc = req_ready;
      step();
      n++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      fail_now("req_accept_timeout");
      return;
    end
    push_expect(a, l, bp);
    idx = 0; n = 0;
    while (idx < int'(l) && n < BOUND) begin
      pl_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      pl_data  = pl_buf[idx];
      @(negedge clock);
      acc = pl_valid && pl_ready;
      step();
      if (acc) idx++;
      n++;
    end
    pl_valid = 1'b0;
    if (idx < int'(l)) fail_now("load_timeout");
    else check("pl_ready_drop", pl_ready, 0);
  endtask

  task automatic send_bad(input logic [1:0] a, input logic [5:0] l);
    bit acc;
    int n;
    req_valid = 1'b1; req_addr = a; req_len = l; req_bad_par = 1'b0;
    acc = 1'b0; n = 0;
    while (!acc && n < BOUND) begin
      @(negedge clock);
      acc = req_ready;
      step();
      n++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      fail_now("bad_req_accept_timeout");
      return;
    end
    @(negedge clock);
    check("req_err_pulse", req_err, 1);
    step();
    @(negedge clock);
    check("req_err_clear", req_err, 0);
    check("req_ready_after_err", req_ready, 1);
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && req_ready) && n < 4000) begin
      step();
      n++;
    end
    if (!(exp_q.size() == 0 && req_ready)) fail_now("idle_timeout");
  endtask

  // Busy driver: optional random busy, plus a one-shot 4-cycle hold on a chosen byte.
  always begin
    @(posedge clock);
    #1;
    if (busy_hold > 0) begin
      busy = 1'b1;
      busy_hold--;
    end else if (trig_en && pkt_valid && pkt_data == trig_byte) begin
      busy      = 1'b1;
      busy_hold = 3;
      trig_en   = 1'b0;
    end else begin
      busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      check("req_ready_in_reset", req_ready, 0);
      check("pl_ready_in_reset", pl_ready, 0);
      in_pkt = 1'b0; wait_par = 1'b0; exp_done = 1'b0; gap_left = 0; exp_cnt = 0;
    end else begin
      check("tx_done", tx_done, exp_done);
      if (exp_done) check("pkt_cnt_at_done", pkt_cnt, exp_cnt);
      exp_done = 1'b0;
      if (gap_left > 0) begin
        check("gap_valid", pkt_valid, 0);
        check("gap_data", pkt_data, 0);
        check("gap_req_ready", req_ready, 0);
        gap_left--;
      end else if (wait_par) begin
        check("parity_valid", pkt_valid, 0);
        if (exp_q.size() == 0) begin
          fail_now("parity_unexpected");
          wait_par = 1'b0;
        end else begin
          mon_e = exp_q[0];
          check("parity_kind", 32'(mon_e.kind), 32'(K_PAR));
          check("parity_data", pkt_data, mon_e.data);
          if (!busy) begin
            void'(exp_q.pop_front());
            wait_par = 1'b0; in_pkt = 1'b0;
            exp_cnt++;
            exp_done = 1'b1;
            gap_left = GAP;
          end
        end
      end else if (pkt_valid || in_pkt) begin
        if (in_pkt) check("pkt_valid_contig", pkt_valid, 1);
        if (exp_q.size() == 0) begin
          fail_now("byte_unexpected");
        end else begin
          mon_e = exp_q[0];
          if (!in_pkt) check("header_kind", 32'(mon_e.kind), 32'(K_HDR));
          check("pkt_byte", pkt_data, mon_e.data);
          if (!busy) begin
            void'(exp_q.pop_front());
            in_pkt = 1'b1;
            if (mon_e.kind == K_LAST) wait_par = 1'b1;
          end
        end
      end
      if (pkt_valid && pkt_data == 8'h22) hold_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [5:0] l;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_req_err", req_err, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_req_ready", req_ready, 1);
    step();

    // Basic packet
    pl_buf = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    wait_idle();
    check("t1_pkt_cnt", pkt_cnt, 1);

    // Same packet with a 4-cycle busy hold on byte 0x22
    hold_cnt  = 0;
    trig_byte = 8'h22;
    trig_en   = 1'b1;
    send_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    wait_idle();
    check("t2_hold_cycles", hold_cnt, 5);
    check("t2_pkt_cnt", pkt_cnt, 2);

    // Rejected requests
    send_bad(2'd0, 6'd0);
    send_bad(2'd3, 6'd5);
    check("t3_pkt_cnt", pkt_cnt, 2);
    check("t3_pkt_valid", pkt_valid, 0);

    // Maximum length with gappy payload
    pl_buf.delete();
    for (int i = 0; i < 63; i++) pl_buf.push_back(8'($urandom));
    send_pkt(2'd2, 6'd63, 1'b0, 1'b1);
    wait_idle();

    // Corrupted parity
    pl_buf = '{8'hA5};
    send_pkt(2'd0, 6'd1, 1'b1, 1'b0);
    wait_idle();
    check("t5_pkt_cnt", pkt_cnt, 4);

    // Reset in the middle of the payload
    pl_buf = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    send_pkt(2'd0, 6'd5, 1'b0, 1'b0);
    n = 0;
    while (!(pkt_valid && pkt_data == 8'h51) && n < BOUND) begin
      step();
      n++;
    end
    if (!(pkt_valid && pkt_data == 8'h51)) fail_now("t6_byte2_timeout");
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    @(negedge clock);
    check("t6_pkt_valid", pkt_valid, 0);
    check("t6_pkt_cnt", pkt_cnt, 0);
    step();
    pl_buf = '{8'h5A, 8'h5B};
    send_pkt(2'd2, 6'd2, 1'b0, 1'b0);
    wait_idle();
    check("t6_pkt_cnt_after", pkt_cnt, 1);

    // Randomised traffic with random busy
    busy_rand = 1'b1;
    for (int p = 0; p < 25; p++) begin
      l = 6'($urandom_range(1, 20));
      pl_buf.delete();
      for (int i = 0; i < int'(l); i++) pl_buf.push_back(8'($urandom));
      send_pkt(2'($urandom_range(0, 2)), l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    busy_rand = 1'b0;
    repeat (4) step();

    check("final_queue_empty", exp_q.size(), 0);
    check("final_pkt_cnt", pkt_cnt, exp_cnt);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
